// File: rtl/ro_worker_pkg.sv
// Shared types and default widths for the ring-oscillator job sequencer.
package ro_worker_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DIV_W_DEF = 4;
  localparam int unsigned STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ro_prescaler.sv
// Free-running modulo-2^DIV_W prescaler; wrap is high on the cycle whose edge rolls it to zero.
module ro_prescaler
  import ro_worker_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [DIV_W-1:0] count,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  assign wrap = &count;

endmodule

// File: rtl/ro_job_sequencer.sv
// Counting job sequencer: serially load a target, count up to it at a selectable rate,
// then unload the result serially.
module ro_job_sequencer
  import ro_worker_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic internal_clock,
  input  logic reset,
  input  logic shift_en,
  input  logic shift_data,
  input  logic start,
  input  logic mode,
  output logic busy,
  output logic done,
  output logic serial_out,
  output logic div_out
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_inc;
  logic               mode_q, mode_d;
  logic               start_q;
  logic               armed_q;
  logic               start_edge;
  logic               step;
  logic               pre_clear;
  logic [DIV_W-1:0]   pre_count;
  logic               pre_wrap;
  logic               unused_pre_bits;

  ro_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (internal_clock),
    .reset (reset),
    .clear (pre_clear),
    .count (pre_count),
    .wrap  (pre_wrap)
  );

  // armed_q blocks a start held high across reset from looking like a rising edge
  assign start_edge = start & ~start_q & armed_q;
  assign step       = mode_q ? pre_wrap : 1'b1;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    mode_d    = mode_q;
    pre_clear = 1'b0;
    count_inc = count_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          count_d = '0;
          if (target_q != '0) begin
            state_d   = ST_RUN;
            pre_clear = 1'b1;
            mode_d    = mode;
          end else begin
            state_d = ST_DONE;
          end
        end else if (shift_en) begin
          target_d = {target_q[CNT_W-2:0], shift_data};
        end
      end
      ST_RUN: begin
        if (step) begin
          count_d = count_inc;
          if (count_inc == target_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start_edge) begin
          state_d = ST_IDLE;
        end else if (shift_en) begin
          count_d = {count_q[CNT_W-2:0], 1'b0};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      start_q  <= start;
      if (!start) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Status decode from registered state and count only
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign serial_out = (state_q == ST_DONE) & count_q[CNT_W-1];
  assign div_out    = pre_count[DIV_W-1];

  // Low prescaler bits are only observed through wrap
  assign unused_pre_bits = ^pre_count[DIV_W-2:0];

endmodule

// File: doc/ro_job_sequencer.md
RO_JOB_SEQUENCER -- requirements
Module: ro_job_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the target and the count registers.
REQ-002 SHALL have parameter DIV_W, default 4, width of the free-running prescaler.
REQ-003 SHALL have internal_clock  input  1  sole clock, ring-oscillator derived; all state updates on posedge.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have shift_en  input  1  shift enable for the target load (IDLE) or the result unload (DONE).
REQ-006 SHALL have shift_data  input  1  serial target bit, MSB-first.
REQ-007 SHALL have start  input  1  job start in IDLE, job acknowledge in DONE; acts on rising edge only.
REQ-008 SHALL have mode  input  1  count-rate select: 0 = every cycle, 1 = every prescaler wrap.
REQ-009 SHALL have busy  output  1  high while in RUN.
REQ-010 SHALL have done  output  1  high while in DONE.
REQ-011 SHALL have serial_out  output  1  result MSB while in DONE, otherwise 0.
REQ-012 SHALL have div_out  output  1  prescaler MSB, for external frequency observation.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE, encoded in 2 bits.
REQ-014 SHALL register start each cycle as start_q; start_edge = start & ~start_q.
REQ-015 IDLE with shift_en=1: target <= {target[CNT_W-2:0], shift_data} on each edge.
REQ-016 IDLE with start_edge and target!=0: go to RUN, clear count and prescaler, latch mode into mode_q; shift_en ignored on that edge.
REQ-017 IDLE with start_edge and target==0: go directly to DONE with count=0.
REQ-018 RUN: count increments on each edge when mode_q=0, or on each edge where prescaler wraps from all-ones to 0 when mode_q=1.
REQ-019 RUN: on the edge where count becomes equal to target, go to DONE; count holds at target; no overshoot.
REQ-020 RUN: start_edge, shift_en, shift_data and mode changes SHALL be ignored; target stays frozen.
REQ-021 DONE with shift_en=1: count <= {count[CNT_W-2:0], 1'b0}; serial_out = count[CNT_W-1].
REQ-022 DONE with start_edge: go to IDLE; target retained, so start_edge in IDLE repeats the same job.
REQ-023 DONE with start_edge and shift_en in the same cycle: start_edge wins; no shift occurs.
REQ-024 Prescaler SHALL free-run, modulo 2^DIV_W, in every state; it is cleared only by reset and by RUN entry.
REQ-025 All arithmetic SHALL be unsigned and wrap modulo register width; count cannot exceed target, since target < 2^CNT_W.

Reset
REQ-026 When reset=1 at an edge, the block SHALL set state=IDLE and set target, count, prescaler, start_q and mode_q to 0, regardless of current state, including mid-RUN.
REQ-027 After reset: busy=0, done=0, serial_out=0, div_out=0; a start held high through reset SHALL NOT produce a start_edge.

Structure
REQ-028 Shared package ro_worker_pkg SHALL hold the state enum typedef, the default CNT_W and DIV_W constants, and the state encodings.
REQ-029 The prescaler SHALL be a sub-module ro_prescaler, with ports clk, reset, clear, count and wrap; the FSM, target, count and start edge detector stay in ro_job_sequencer.
REQ-030 Outputs busy, done and serial_out SHALL be decoded from registered state and count only; they SHALL have no combinational path from any input.

Verification (CNT_W=16, DIV_W=4; start_edge sampled at edge k)
REQ-031 Reset: assert reset for 2 cycles with start=1 -> busy=0, done=0, serial_out=0, div_out=0; no job starts after reset is released.
REQ-032 Shift in 0x0005 over 16 cycles, mode=0, pulse start -> busy=1 after edge k, done=1 after edge k+5, busy=0.
REQ-033 Shift in 0x0003, mode=1, pulse start -> done=1 after edge k+48; div_out toggles every 8 cycles.
REQ-034 Target 0x0000, pulse start -> done=1 after edge k; busy never asserts; result shifts out as 0x0000.
REQ-035 Target 0xA5C3, mode=0 run to DONE, then 16 shift_en cycles -> serial_out sequence = 0xA5C3 MSB-first; start pulse -> IDLE, done=0.
REQ-036 Target 0x0100, start, assert reset at edge k+50 -> IDLE and busy=0 next edge; target reads back 0 (a start immediately gives DONE at once).
